// File: rtl/mac_ctrl_vert_16.sv
// Column-serial MAC sequencer: accepts one job, then streams its bit columns MSB first
// into the MAC stage, followed by flush cycles and a one-cycle completion pulse.
module mac_ctrl_vert_16 #(
    parameter int MUX_SEL_WIDTH = 5,
    parameter int FLUSH_CYCLES  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [2:0]               job_ncol,
    input  logic                     job_skip_zero,
    input  logic                     col_valid,
    output logic                     col_ready,
    input  logic [2:0]               col_mul_const,
    input  logic                     col_is_shift_mul,
    input  logic [MUX_SEL_WIDTH-1:0] col_hamming_sel,
    input  logic                     col_hamming_sign,
    output logic                     act_load,
    output logic                     mac_clr,
    output logic                     en,
    output logic                     flush,
    output logic [2:0]               column_idx,
    output logic                     is_msb,
    output logic                     is_skip_zero,
    output logic [2:0]               mul_const,
    output logic                     is_shift_mul,
    output logic [MUX_SEL_WIDTH-1:0] hamming_sel,
    output logic                     hamming_sign,
    output logic                     busy,
    output logic                     done
);

    localparam int DRAIN_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(FLUSH_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                   state_reg, state_next;
    logic [2:0]               ncol_reg, ncol_next;
    logic                     skip_zero_reg, skip_zero_next;
    logic [2:0]               col_cnt_reg, col_cnt_next;
    logic [DRAIN_W-1:0]       drain_cnt_reg, drain_cnt_next;

    // MAC-side outputs are all registered one cycle after the column accept
    logic                     en_reg, en_next;
    logic                     flush_reg, flush_next;
    logic [2:0]               column_idx_reg, column_idx_next;
    logic                     is_msb_reg, is_msb_next;
    logic                     is_skip_zero_reg, is_skip_zero_next;
    logic [2:0]               mul_const_reg, mul_const_next;
    logic                     is_shift_mul_reg, is_shift_mul_next;
    logic [MUX_SEL_WIDTH-1:0] hamming_sel_reg, hamming_sel_next;
    logic                     hamming_sign_reg, hamming_sign_next;

    logic                     job_ready_c;
    logic                     col_ready_c;
    logic                     act_load_c;
    logic                     mac_clr_c;
    logic                     done_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= ST_IDLE;
            ncol_reg         <= '0;
            skip_zero_reg    <= 1'b0;
            col_cnt_reg      <= '0;
            drain_cnt_reg    <= '0;
            en_reg           <= 1'b0;
            flush_reg        <= 1'b0;
            column_idx_reg   <= '0;
            is_msb_reg       <= 1'b0;
            is_skip_zero_reg <= 1'b0;
            mul_const_reg    <= '0;
            is_shift_mul_reg <= 1'b0;
            hamming_sel_reg  <= '0;
            hamming_sign_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            ncol_reg         <= ncol_next;
            skip_zero_reg    <= skip_zero_next;
            col_cnt_reg      <= col_cnt_next;
            drain_cnt_reg    <= drain_cnt_next;
            en_reg           <= en_next;
            flush_reg        <= flush_next;
            column_idx_reg   <= column_idx_next;
            is_msb_reg       <= is_msb_next;
            is_skip_zero_reg <= is_skip_zero_next;
            mul_const_reg    <= mul_const_next;
            is_shift_mul_reg <= is_shift_mul_next;
            hamming_sel_reg  <= hamming_sel_next;
            hamming_sign_reg <= hamming_sign_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        ncol_next         = ncol_reg;
        skip_zero_next    = skip_zero_reg;
        col_cnt_next      = col_cnt_reg;
        drain_cnt_next    = drain_cnt_reg;
        en_next           = 1'b0;
        flush_next        = 1'b0;
        column_idx_next   = '0;
        is_msb_next       = 1'b0;
        is_skip_zero_next = 1'b0;
        mul_const_next    = '0;
        is_shift_mul_next = 1'b0;
        hamming_sel_next  = '0;
        hamming_sign_next = 1'b0;
        job_ready_c       = 1'b0;
        col_ready_c       = 1'b0;
        act_load_c        = 1'b0;
        mac_clr_c         = 1'b0;
        done_c            = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                job_ready_c = 1'b1;
                if (job_valid) begin
                    ncol_next      = job_ncol;
                    skip_zero_next = job_skip_zero;
                    col_cnt_next   = job_ncol;
                    state_next     = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                mac_clr_c  = 1'b1;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                col_ready_c = 1'b1;
                if (col_valid) begin
                    act_load_c        = 1'b1;
                    en_next           = 1'b1;
                    column_idx_next   = col_cnt_reg;
                    is_msb_next       = (col_cnt_reg == ncol_reg);
                    is_skip_zero_next = skip_zero_reg;
                    mul_const_next    = col_mul_const;
                    is_shift_mul_next = col_is_shift_mul;
                    hamming_sel_next  = col_hamming_sel;
                    hamming_sign_next = col_hamming_sign;
                    // Last column: leave RUN instead of decrementing, so col_cnt never wraps
                    if (col_cnt_reg == 3'd0) begin
                        drain_cnt_next = '0;
                        state_next     = ST_DRAIN;
                    end else begin
                        col_cnt_next = col_cnt_reg - 3'd1;
                    end
                end
            end
            ST_DRAIN: begin
                // Cycle 0 of DRAIN shows the last column; later cycles are flushes
                if (drain_cnt_reg == DRAIN_LAST) begin
                    state_next = ST_DONE;
                end else begin
                    en_next        = 1'b1;
                    flush_next     = 1'b1;
                    drain_cnt_next = drain_cnt_reg + DRAIN_W'(1);
                end
            end
            ST_DONE: begin
                done_c     = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // job_ready must stay low for the whole time reset is held, even though state is IDLE
    assign job_ready    = job_ready_c & reset;
    assign col_ready    = col_ready_c;
    assign act_load     = act_load_c;
    assign mac_clr      = mac_clr_c;
    assign done         = done_c;
    assign busy         = (state_reg != ST_IDLE);

    assign en           = en_reg;
    assign flush        = flush_reg;
    assign column_idx   = column_idx_reg;
    assign is_msb       = is_msb_reg;
    assign is_skip_zero = is_skip_zero_reg;
    assign mul_const    = mul_const_reg;
    assign is_shift_mul = is_shift_mul_reg;
    assign hamming_sel  = hamming_sel_reg;
    assign hamming_sign = hamming_sign_reg;

endmodule

// File: tb/tb_mac_ctrl_vert_16.sv
// Scoreboard bench for mac_ctrl_vert_16: stimulus pushes expected strobes and MAC payloads
// per cycle; a negedge monitor pops and compares them against the DUT every cycle.
module tb_mac_ctrl_vert_16;

    localparam int SEL_W = 5;
    localparam int FLUSH = 1;
    localparam int PAY_W = 11 + SEL_W;

    logic             clk;
    logic             reset;
    logic             job_valid;
    logic             job_ready;
    logic [2:0]       job_ncol;
    logic             job_skip_zero;
    logic             col_valid;
    logic             col_ready;
    logic [2:0]       col_mul_const;
    logic             col_is_shift_mul;
    logic [SEL_W-1:0] col_hamming_sel;
    logic             col_hamming_sign;
    logic             act_load;
    logic             mac_clr;
    logic             en;
    logic             flush;
    logic [2:0]       column_idx;
    logic             is_msb;
    logic             is_skip_zero;
    logic [2:0]       mul_const;
    logic             is_shift_mul;
    logic [SEL_W-1:0] hamming_sel;
    logic             hamming_sign;
    logic             busy;
    logic             done;

    typedef struct {
        int               cyc;
        logic [PAY_W-1:0] pay;
    } exp_t;

    exp_t en_q[$];
    int   act_q[$];
    int   clr_q[$];
    int   done_q[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    mac_ctrl_vert_16 #(
        .MUX_SEL_WIDTH(SEL_W),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .job_valid       (job_valid),
        .job_ready       (job_ready),
        .job_ncol        (job_ncol),
        .job_skip_zero   (job_skip_zero),
        .col_valid       (col_valid),
        .col_ready       (col_ready),
        .col_mul_const   (col_mul_const),
        .col_is_shift_mul(col_is_shift_mul),
        .col_hamming_sel (col_hamming_sel),
        .col_hamming_sign(col_hamming_sign),
        .act_load        (act_load),
        .mac_clr         (mac_clr),
        .en              (en),
        .flush           (flush),
        .column_idx      (column_idx),
        .is_msb          (is_msb),
        .is_skip_zero    (is_skip_zero),
        .mul_const       (mul_const),
        .is_shift_mul    (is_shift_mul),
        .hamming_sel     (hamming_sel),
        .hamming_sign    (hamming_sign),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Per-cycle monitor: strobes and the MAC payload bundle (zero whenever en is not expected)
    always @(negedge clk) begin
        logic             exp_bit;
        logic [PAY_W-1:0] exp_pay;
        logic [PAY_W-1:0] obs_pay;
        obs_pay = {column_idx, is_msb, is_skip_zero, mul_const, is_shift_mul,
                   hamming_sel, hamming_sign, flush};
        exp_pay = '0;
        exp_bit = (en_q.size() > 0) && (en_q[0].cyc == cyc);
        if (exp_bit) begin
            exp_pay = en_q[0].pay;
            void'(en_q.pop_front());
        end
        check("en", 64'(en), 64'(exp_bit));
        check("payload", 64'(obs_pay), 64'(exp_pay));

        exp_bit = (act_q.size() > 0) && (act_q[0] == cyc);
        if (exp_bit) void'(act_q.pop_front());
        check("act_load", 64'(act_load), 64'(exp_bit));

        exp_bit = (clr_q.size() > 0) && (clr_q[0] == cyc);
        if (exp_bit) void'(clr_q.pop_front());
        check("mac_clr", 64'(mac_clr), 64'(exp_bit));

        exp_bit = (done_q.size() > 0) && (done_q[0] == cyc);
        if (exp_bit) void'(done_q.pop_front());
        check("done", 64'(done), 64'(exp_bit));
    end

    task automatic drive_payload(input logic use_fixed, input logic [2:0] f_mul, input logic f_shift,
                                 input logic [SEL_W-1:0] f_sel, input logic f_sign);
        if (use_fixed) begin
            col_mul_const    = f_mul;
            col_is_shift_mul = f_shift;
            col_hamming_sel  = f_sel;
            col_hamming_sign = f_sign;
        end else begin
            col_mul_const    = 3'($urandom);
            col_is_shift_mul = 1'($urandom);
            col_hamming_sel  = SEL_W'($urandom);
            col_hamming_sign = 1'($urandom);
        end
    endtask

    // One job; cycle 0 is the job-accept cycle, stall_mask[r]=1 drops col_valid in cycle r
    task automatic run_job(input logic [2:0] ncol, input logic skip, input logic [63:0] stall_mask,
                           input logic use_fixed, input logic [2:0] f_mul, input logic f_shift,
                           input logic [SEL_W-1:0] f_sel, input logic f_sign);
        int   c0;
        int   remaining;
        int   done_rel;
        logic [2:0] k;
        exp_t e;
        @(posedge clk); #1;
        c0            = cyc;
        job_valid     = 1'b1;
        job_ncol      = ncol;
        job_skip_zero = skip;
        col_valid     = 1'b1;
        drive_payload(use_fixed, f_mul, f_shift, f_sel, f_sign);
        clr_q.push_back(c0 + 1);
        remaining = int'(ncol) + 1;
        k         = ncol;
        done_rel  = 1000;
        @(negedge clk);
        check("job_ready_idle", 64'(job_ready), 64'd1);
        check("busy_idle", 64'(busy), 64'd0);
        for (int rel = 1; rel <= done_rel + 1 && rel < 60; rel++) begin
            @(posedge clk); #1;
            job_valid     = 1'b0;
            job_ncol      = 3'($urandom);
            job_skip_zero = 1'($urandom);
            col_valid     = ~stall_mask[rel];
            drive_payload(use_fixed, f_mul, f_shift, f_sel, f_sign);
            if (col_valid && rel >= 2 && remaining > 0) begin
                act_q.push_back(c0 + rel);
                e.cyc = c0 + rel + 1;
                e.pay = {k, (k == ncol), skip, col_mul_const, col_is_shift_mul,
                         col_hamming_sel, col_hamming_sign, 1'b0};
                en_q.push_back(e);
                remaining--;
                if (remaining == 0) begin
                    for (int f = 1; f <= FLUSH; f++) begin
                        e.cyc = c0 + rel + 1 + f;
                        e.pay = PAY_W'(1);
                        en_q.push_back(e);
                    end
                    done_rel = rel + 2 + FLUSH;
                    done_q.push_back(c0 + done_rel);
                end else begin
                    k = k - 3'd1;
                end
            end
            @(negedge clk);
            if (rel == 1) begin
                check("job_ready_clear", 64'(job_ready), 64'd0);
                check("col_ready_clear", 64'(col_ready), 64'd0);
                check("busy_clear", 64'(busy), 64'd1);
            end
            if (rel == 2) check("col_ready_run", 64'(col_ready), 64'd1);
            if (rel == done_rel) check("job_ready_done", 64'(job_ready), 64'd0);
            if (rel == done_rel + 1) begin
                check("job_ready_after", 64'(job_ready), 64'd1);
                check("busy_after", 64'(busy), 64'd0);
            end
        end
        col_valid = 1'b0;
        $display("job ncol=%0d skip=%0d stalls=%0h done_rel=%0d errors_so_far=%0d",
                 ncol, skip, stall_mask, done_rel, n_bad);
    endtask

    initial begin
        int   c0;
        exp_t e;
        reset = 1'b1;
        job_valid = 1'b0;
        job_ncol = 3'd0;
        job_skip_zero = 1'b0;
        col_valid = 1'b0;
        col_mul_const = 3'd0;
        col_is_shift_mul = 1'b0;
        col_hamming_sel = '0;
        col_hamming_sign = 1'b0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_job_ready", 64'(job_ready), 64'd0);
        check("rst_col_ready", 64'(col_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("rst_release_job_ready", 64'(job_ready), 64'd1);

        run_job(3'd0, 1'b0, 64'd0, 1'b0, 3'd0, 1'b0, '0, 1'b0);
        run_job(3'd7, 1'b0, 64'd0, 1'b0, 3'd0, 1'b0, '0, 1'b0);
        run_job(3'd2, 1'b0, 64'h18, 1'b0, 3'd0, 1'b0, '0, 1'b0);
        run_job(3'd3, 1'b1, 64'd0, 1'b1, 3'd5, 1'b1, SEL_W'(16), 1'b1);
        run_job(3'd5, 1'($urandom), 64'($urandom) & 64'h0FFC, 1'b0, 3'd0, 1'b0, '0, 1'b0);

        // Mid-RUN: a second job offer is ignored, then reset abandons the job
        @(posedge clk); #1;
        c0 = cyc;
        job_valid = 1'b1;
        job_ncol = 3'd7;
        job_skip_zero = 1'b0;
        col_valid = 1'b0;
        clr_q.push_back(c0 + 1);
        @(posedge clk); #1 job_valid = 1'b0;
        for (int rel = 2; rel <= 4; rel++) begin
            @(posedge clk); #1;
            job_valid = (rel == 3);
            job_ncol = 3'd1;
            col_valid = 1'b1;
            drive_payload(1'b0, 3'd0, 1'b0, '0, 1'b0);
            act_q.push_back(c0 + rel);
            e.cyc = c0 + rel + 1;
            e.pay = {3'(9 - rel), (rel == 2), 1'b0, col_mul_const, col_is_shift_mul,
                     col_hamming_sel, col_hamming_sign, 1'b0};
            en_q.push_back(e);
            @(negedge clk);
            check("run_job_ready", 64'(job_ready), 64'd0);
            check("run_busy", 64'(busy), 64'd1);
        end
        @(posedge clk); #1;
        job_valid = 1'b0;
        reset = 1'b0;
        en_q.delete();
        @(negedge clk);
        check("midrst_job_ready", 64'(job_ready), 64'd0);
        check("midrst_col_ready", 64'(col_ready), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        col_valid = 1'b0;
        @(negedge clk);
        check("postrst_job_ready", 64'(job_ready), 64'd1);
        check("postrst_busy", 64'(busy), 64'd0);
        repeat (10) @(negedge clk);
        $display("reset mid-run abandoned job errors_so_far=%0d", n_bad);

        check("queues_drained", 64'(en_q.size() + act_q.size() + clr_q.size() + done_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
